m_ram_reader: RTL

//  Read-side companion to the 64x4 switch-written RAM: drives the RAM address, captures read data
//  and presents {address, data} as hex nibbles for the 7-segment decoders.

---
 rtl/m_ram_reader_pkg.sv | 12 +
 rtl/m_ram_reader_rise_edge.sv | 18 +
 rtl/m_ram_reader.sv | 97 +++++++++
 3 files changed

// File: rtl/m_ram_reader_pkg.sv
// Shared widths and state encoding for the RAM read-side controller.
package m_ram_reader_pkg;

  localparam int RAM_ADR_W = 6;
  localparam int RAM_DAT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/m_ram_reader_rise_edge.sv
// Rising-edge detector for a debounced button level; one history flop.
module m_rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  logic in_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign out = in & ~in_q;

endmodule

// File: rtl/m_ram_reader.sv
// RAM read-side controller: single-step / scan / clear of the read address,
// data capture one cycle after each address change, hex digits for display.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | address held; step edge advances by one (always wraps)
//   ST_RUN  | address advances on every prescaler tick; step ignored
module m_ram_reader
  import m_ram_reader_pkg::*;
#(
  parameter int ADR_W  = RAM_ADR_W,
  parameter int DAT_W  = RAM_DAT_W,
  parameter int TICK_W = 24,
  parameter bit WRAP   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_clr,
  input  logic [DAT_W-1:0] rdata,
  output logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] dat,
  output logic             dat_vld,
  output logic             running,
  output logic             wrap_p,
  output logic [3:0]       hex_ah,
  output logic [3:0]       hex_al
);

  logic run_e, step_e, clr_e;
  state_t state;
  logic [TICK_W-1:0] presc;
  logic tick, at_last, adv, stop;

  m_rise_edge u_run  (.clk(clk), .rst_n(rst_n), .in(btn_run),  .out(run_e));
  m_rise_edge u_step (.clk(clk), .rst_n(rst_n), .in(btn_step), .out(step_e));
  m_rise_edge u_clr  (.clk(clk), .rst_n(rst_n), .in(btn_clr),  .out(clr_e));

  // Down-counter loaded with all-ones on RUN entry: terminal count at zero
  // gives the first tick 2**TICK_W cycles later, then every 2**TICK_W.
  assign tick    = (state == ST_RUN) && (presc == '0);
  assign at_last = (adr == {ADR_W{1'b1}});

  // clr and run toggle pre-empt any advance in the same cycle.
  assign adv  = !clr_e && !run_e &&
                (((state == ST_IDLE) && step_e) || (tick && (WRAP || !at_last)));
  assign stop = !clr_e && !run_e && tick && !WRAP && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      presc   <= '0;
      adr     <= '0;
      dat     <= '0;
      dat_vld <= 1'b0;
      running <= 1'b0;
      wrap_p  <= 1'b0;
    end else begin
      wrap_p <= 1'b0;
      if (state == ST_RUN) presc <= presc - TICK_W'(1);

      if (clr_e) begin
        state   <= ST_IDLE;
        running <= 1'b0;
        adr     <= '0;
      end else if (run_e) begin
        if (state == ST_IDLE) begin
          state   <= ST_RUN;
          running <= 1'b1;
          presc   <= '1;
        end else begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      end else if (adv) begin
        adr    <= adr + ADR_W'(1);
        wrap_p <= at_last;
      end else if (stop) begin
        state   <= ST_IDLE;
        running <= 1'b0;
        wrap_p  <= 1'b1;
      end

      if (clr_e || adv) begin
        dat_vld <= 1'b0;
      end else begin
        dat     <= rdata;
        dat_vld <= 1'b1;
      end
    end
  end

  assign hex_ah = 4'(adr >> 4);
  assign hex_al = adr[3:0];

endmodule
